// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: writeback-source select,
// memory-op "no request" code and the memory-wait FSM states.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] wb_valD_sel_valM = 2'd1;
    localparam logic [3:0] mem_no_rw        = 4'h0;

    typedef enum logic [1:0] {
        ctrl_st_run      = 2'd0,
        ctrl_st_mem_wait = 2'd1,
        ctrl_st_hang     = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the controller's performance counters.
module hazard_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble generator for the 5-stage pipe: load-use, mispredict flush and
// data-memory wait with a hang watchdog, plus stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       decode_i_rs1,
    input  logic [4:0]       decode_i_rs2,
    input  logic             decode_i_rs1_used,
    input  logic             decode_i_rs2_used,
    input  logic             regE_i_wb_reg_wen,
    input  logic [4:0]       regE_i_wb_rd,
    input  logic [1:0]       regE_i_wb_valD_sel,
    input  logic             execute_i_mispredict,
    input  logic [3:0]       regM_i_mem_rw,
    input  logic             dmem_i_ready,
    output logic             ctrl_o_regF_stall,
    output logic             ctrl_o_regD_stall,
    output logic             ctrl_o_regD_bubble,
    output logic             ctrl_o_regE_stall,
    output logic             ctrl_o_regE_bubble,
    output logic             ctrl_o_regM_stall,
    output logic             ctrl_o_regW_bubble,
    output logic             ctrl_o_mem_timeout,
    output logic [CNT_W-1:0] ctrl_o_stall_cycles,
    output logic [CNT_W-1:0] ctrl_o_flush_count
);

    localparam int WCW = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;
    localparam logic [WCW-1:0] TO_VAL = WCW'(MEM_TIMEOUT);

    ctrl_state_e    r_state, w_state_nxt;
    logic [WCW-1:0] r_wait_cnt, w_wait_nxt;
    logic           r_timeout, w_timeout_nxt;

    logic w_mem_req, w_mem_stall, w_load_use, w_flush, w_any_stall;

    assign w_mem_req = (regM_i_mem_rw != mem_no_rw);

    assign w_mem_stall = (r_state == ctrl_st_run      && w_mem_req && !dmem_i_ready) ||
                         (r_state == ctrl_st_mem_wait && !dmem_i_ready) ||
                         (r_state == ctrl_st_hang);

    assign w_load_use = regE_i_wb_reg_wen &&
                        (regE_i_wb_valD_sel == wb_valD_sel_valM) &&
                        (regE_i_wb_rd != 5'd0) &&
                        ((decode_i_rs1_used && decode_i_rs1 == regE_i_wb_rd) ||
                         (decode_i_rs2_used && decode_i_rs2 == regE_i_wb_rd));

    assign w_flush     = rst && !w_mem_stall && execute_i_mispredict;
    assign w_any_stall = ctrl_o_regF_stall | ctrl_o_regD_stall |
                         ctrl_o_regE_stall | ctrl_o_regM_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ctrl_st_run;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_nxt = r_timeout;

        case (r_state)
            ctrl_st_run: begin
                if (w_mem_req && !dmem_i_ready) begin
                    w_state_nxt = ctrl_st_mem_wait;
                    w_wait_nxt  = WCW'(1);
                end
            end
            ctrl_st_mem_wait: begin
                if (dmem_i_ready) begin
                    w_state_nxt = ctrl_st_run;
                    w_wait_nxt  = '0;
                end else if (MEM_TIMEOUT != 0 && r_wait_cnt == TO_VAL) begin
                    w_state_nxt   = ctrl_st_hang;
                    w_timeout_nxt = 1'b1;
                end else if (r_wait_cnt != '1) begin
                    // Saturate so a disabled watchdog never wraps the count.
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            ctrl_st_hang: ;
            default: begin
                w_state_nxt = ctrl_st_run;
                w_wait_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        ctrl_o_regF_stall  = 1'b0;
        ctrl_o_regD_stall  = 1'b0;
        ctrl_o_regD_bubble = 1'b0;
        ctrl_o_regE_stall  = 1'b0;
        ctrl_o_regE_bubble = 1'b0;
        ctrl_o_regM_stall  = 1'b0;
        ctrl_o_regW_bubble = 1'b0;

        if (!rst) begin
            ctrl_o_regD_bubble = 1'b1;
            ctrl_o_regE_bubble = 1'b1;
            ctrl_o_regW_bubble = 1'b1;
        end else if (w_mem_stall) begin
            // E is held, so a pending mispredict/load-use resurfaces once M drains.
            ctrl_o_regF_stall  = 1'b1;
            ctrl_o_regD_stall  = 1'b1;
            ctrl_o_regE_stall  = 1'b1;
            ctrl_o_regM_stall  = 1'b1;
            ctrl_o_regW_bubble = 1'b1;
        end else if (execute_i_mispredict) begin
            ctrl_o_regD_bubble = 1'b1;
            ctrl_o_regE_bubble = 1'b1;
        end else if (w_load_use) begin
            ctrl_o_regF_stall  = 1'b1;
            ctrl_o_regD_stall  = 1'b1;
            ctrl_o_regE_bubble = 1'b1;
        end
    end

    assign ctrl_o_mem_timeout = r_timeout;

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_any_stall),
        .count (ctrl_o_stall_cycles)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush),
        .count (ctrl_o_flush_count)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle behavioural model check
// plus hand-computed literal expectations per scenario.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    // Control vector order: {F stall, D stall, D bubble, E stall, E bubble, M stall, W bubble}
    localparam logic [6:0] O_RST  = 7'b0010101;
    localparam logic [6:0] O_MEM  = 7'b1101011;
    localparam logic [6:0] O_FLSH = 7'b0010100;
    localparam logic [6:0] O_LU   = 7'b1100100;
    localparam logic [6:0] O_NONE = 7'b0000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] rs1, rs2, rd;
    logic rs1_used, rs2_used, wen, mispred, rdy;
    logic [1:0] sel;
    logic [3:0] mem_rw;
    logic f_st, d_st, d_bub, e_st, e_bub, m_st, w_bub, tmo;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .decode_i_rs1         (rs1),
        .decode_i_rs2         (rs2),
        .decode_i_rs1_used    (rs1_used),
        .decode_i_rs2_used    (rs2_used),
        .regE_i_wb_reg_wen    (wen),
        .regE_i_wb_rd         (rd),
        .regE_i_wb_valD_sel   (sel),
        .execute_i_mispredict (mispred),
        .regM_i_mem_rw        (mem_rw),
        .dmem_i_ready         (rdy),
        .ctrl_o_regF_stall    (f_st),
        .ctrl_o_regD_stall    (d_st),
        .ctrl_o_regD_bubble   (d_bub),
        .ctrl_o_regE_stall    (e_st),
        .ctrl_o_regE_bubble   (e_bub),
        .ctrl_o_regM_stall    (m_st),
        .ctrl_o_regW_bubble   (w_bub),
        .ctrl_o_mem_timeout   (tmo),
        .ctrl_o_stall_cycles  (stall_cnt),
        .ctrl_o_flush_count   (flush_cnt)
    );

    wire [6:0] outs = {f_st, d_st, d_bub, e_st, e_bub, m_st, w_bub};

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: 0 = running, 1 = waiting on memory, 2 = hung.
    int m_mode = 0, m_wait = 0, m_to = 0, m_sc = 0, m_fc = 0;

    always @(negedge clk) begin
        logic [6:0] exp_o;
        bit req, lu, mstall;
        if (!rst) begin
            m_mode = 0; m_wait = 0; m_to = 0; m_sc = 0; m_fc = 0;
            chk("cmp_ctl_rst", int'(outs), int'(O_RST));
            chk("cmp_cnt_rst", int'(stall_cnt) + int'(flush_cnt) + int'(tmo), 0);
        end else begin
            req = (mem_rw != mem_no_rw);
            lu  = wen && sel == wb_valD_sel_valM && rd != 0 &&
                  ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
            mstall = (m_mode == 2) || (!rdy && (m_mode == 1 || req));
            if (mstall)       exp_o = O_MEM;
            else if (mispred) exp_o = O_FLSH;
            else if (lu)      exp_o = O_LU;
            else              exp_o = O_NONE;
            chk("cmp_ctl", int'(outs), int'(exp_o));
            chk("cmp_stall_cnt", int'(stall_cnt), m_sc);
            chk("cmp_flush_cnt", int'(flush_cnt), m_fc);
            chk("cmp_timeout", int'(tmo), m_to);
            if (exp_o[6]) m_sc = (m_sc == CMAX) ? CMAX : m_sc + 1;
            if (exp_o == O_FLSH) m_fc = (m_fc == CMAX) ? CMAX : m_fc + 1;
            if (m_mode == 0 && req && !rdy) begin
                m_mode = 1; m_wait = 1;
            end else if (m_mode == 1) begin
                if (rdy)              begin m_mode = 0; m_wait = 0; end
                else if (m_wait == TO) begin m_mode = 2; m_to = 1; end
                else                   m_wait++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0;
        wen = 0; sel = 2'd0; mispred = 0; mem_rw = mem_no_rw; rdy = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        idle();
        cyc(); cyc();
        rst = 1;
    endtask

    task automatic set_lu(input logic [4:0] r);
        wen = 1; sel = wb_valD_sel_valM; rd = r; rs1 = r; rs1_used = 1;
    endtask

    initial begin
        idle();
        cyc(); cyc();
        #1;
        chk("reset_ctl", int'(outs), int'(O_RST));
        chk("reset_stall_cnt", int'(stall_cnt), 0);
        rst = 1;
        cyc();

        // Load-use hazard and its boundary cases
        set_lu(5'd5);
        #1 chk("lu_rs1", int'(outs), int'(O_LU));
        cyc();
        wen = 0;
        #1 chk("lu_released", int'(outs), int'(O_NONE));
        cyc();
        set_lu(5'd0);
        #1 chk("lu_x0", int'(outs), int'(O_NONE));
        cyc();
        set_lu(5'd5); sel = 2'd0;
        #1 chk("lu_nonload", int'(outs), int'(O_NONE));
        cyc();
        set_lu(5'd7); rs1_used = 0; rs2 = 5'd7; rs2_used = 1;
        #1 chk("lu_rs2", int'(outs), int'(O_LU));
        cyc();
        rs2_used = 0;
        #1 chk("lu_unused_src", int'(outs), int'(O_NONE));
        chk("lu_stall_cnt", int'(stall_cnt), 2);
        cyc();

        // Mispredict beats load-use
        do_reset();
        set_lu(5'd3); mispred = 1;
        #1 chk("flush_ctl", int'(outs), int'(O_FLSH));
        cyc();
        idle();
        #1 chk("flush_cnt", int'(flush_cnt), 1);
        chk("flush_no_stall", int'(stall_cnt), 0);
        cyc();

        // Memory wait with a suppressed mispredict
        do_reset();
        mem_rw = 4'h2; rdy = 0; mispred = 1; set_lu(5'd9);
        for (int i = 0; i < 3; i++) begin
            #1 chk("mem_wait_ctl", int'(outs), int'(O_MEM));
            cyc();
        end
        rdy = 1;
        #1 chk("mem_release_flush", int'(outs), int'(O_FLSH));
        cyc();
        idle();
        #1 chk("mem_stall_cnt", int'(stall_cnt), 3);
        chk("mem_flush_cnt", int'(flush_cnt), 1);
        mem_rw = 4'h1; rdy = 1;
        #1 chk("mem_ready_first", int'(outs), int'(O_NONE));
        cyc();
        for (int i = 0; i < 2; i++) begin
            mem_rw = 4'h3; rdy = 0;
            cyc();
            rdy = 1;
            #1 chk("mem_b2b_release", int'(outs), int'(O_NONE));
            cyc();
        end
        idle();
        #1 chk("mem_b2b_stall_cnt", int'(stall_cnt), 5);
        cyc();

        // Watchdog timeout into HANG
        do_reset();
        mem_rw = 4'h2; rdy = 0;
        repeat (4) cyc();
        chk("tmo_not_yet", int'(tmo), 0);
        cyc();
        chk("tmo_set", int'(tmo), 1);
        rdy = 1;
        #1 chk("hang_ignores_ready", int'(outs), int'(O_MEM));
        cyc();
        idle();
        #1 chk("hang_sticky_ctl", int'(outs), int'(O_MEM));
        chk("hang_sticky_tmo", int'(tmo), 1);
        cyc();
        rst = 0;
        #1 chk("hang_async_rst_tmo", int'(tmo), 0);
        chk("hang_async_rst_ctl", int'(outs), int'(O_RST));
        cyc();

        // Async reset mid memory wait, no clock edge
        do_reset();
        mem_rw = 4'h2; rdy = 0;
        cyc(); cyc();
        idle();
        rst = 0;
        #1 chk("async_rst_ctl", int'(outs), int'(O_RST));
        chk("async_rst_cnt", int'(stall_cnt), 0);
        #6 rst = 1;
        cyc();
        #1 chk("post_rst_ctl", int'(outs), int'(O_NONE));
        chk("post_rst_cnt", int'(stall_cnt), 0);
        cyc();

        // Counter saturation
        do_reset();
        mem_rw = 4'h2; rdy = 0;
        repeat (20) cyc();
        chk("sat_stall_cnt", int'(stall_cnt), 15);
        cyc();
        chk("sat_stall_hold", int'(stall_cnt), 15);

        do_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
